// File: rtl/weight_loader.sv
// Weight loader: stages one kernel of weight words from a valid/ready stream, then flushes
// them to the downstream weight buffer as one flush pulse followed by ks streamed words.
module weight_loader #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BUFFER_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            kernel_size,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  flush,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush_busy,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned IdxW  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [7:0]  MaxKs = 8'(BUFFER_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StFlush,
    StStream,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            ks_q, ks_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic [7:0]            ks_last;
  logic                  accept;
  logic [DATA_WIDTH-1:0] stage_q [BUFFER_DEPTH];

  assign ks_last = ks_q - 8'd1;
  assign accept  = (state_q == StFill) && s_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ks_q    <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ks_q    <= ks_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Staging RAM is deliberately not reset; entries are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      stage_q[wcnt_q[IdxW-1:0]] <= s_data;
    end
  end

  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    s_ready = 1'b0;
    flush   = 1'b0;
    wb_data = '0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          ks_d    = kernel_size;
          wcnt_d  = '0;
          state_d = ((kernel_size == 8'd0) || (kernel_size > MaxKs)) ? StErr : StFill;
        end
      end
      StFill: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q == ks_last) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (!flush_busy) begin
          flush   = 1'b1;
          rcnt_d  = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        wb_data = stage_q[rcnt_q[IdxW-1:0]];
        rcnt_d  = rcnt_q + 8'd1;
        if (rcnt_q == ks_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
